// File: rtl/barrett_modmul_pipe.sv
// Barrett modular multiplier C = (A*B) mod P: operand register plus four compute stages, result 4 cycles after acceptance.
// One global enable stalls every stage while out_valid is held without out_ready; in_ready drops with it.
module barrett_modmul_pipe #(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_p,
  input  logic [W:0]       cfg_t,
  output logic             cfg_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_c,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
  } op_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [2*W-1:0]   x;
  } prod_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [W+1:0]     xl;
    logic [W:0]       q;
  } quot_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [W+1:0]     r;
  } rem_t;

  logic [W-1:0] p_q;
  logic [W:0]   t_q;
  logic         loaded_q;

  op_t   s0_q, s0_d;
  prod_t s1_q, s1_d;
  quot_t s2_q, s2_d;
  rem_t  s3_q, s3_d;

  logic         en;
  logic         take;
  logic [W:0]   x_hi;
  logic [W+1:0] qp_lo;
  logic [W+1:0] p1;
  logic [W+1:0] p2;
  logic [W-1:0] c_d;

  assign en        = !out_valid || out_ready;
  assign cfg_ready = !(s0_q.vld || s1_q.vld || s2_q.vld || s3_q.vld || out_valid);
  assign in_ready  = en && loaded_q && !cfg_we;
  assign take      = in_valid && in_ready;

  // Only the top W+1 bits of X feed the quotient estimate; the low W+2 bits feed the remainder.
  assign x_hi  = s1_q.x[2*W-1:W-1];
  assign qp_lo = {1'b0, s2_q.q} * {2'b00, p_q};
  assign p1    = {2'b00, p_q};
  assign p2    = {1'b0, p_q, 1'b0};

  always_comb begin
    s0_d     = '0;
    s0_d.vld = take;
    s0_d.tag = in_tag;
    s0_d.a   = in_a;
    s0_d.b   = in_b;

    s1_d     = '0;
    s1_d.vld = s0_q.vld;
    s1_d.tag = s0_q.tag;
    s1_d.x   = {{W{1'b0}}, s0_q.a} * {{W{1'b0}}, s0_q.b};

    s2_d     = '0;
    s2_d.vld = s1_q.vld;
    s2_d.tag = s1_q.tag;
    s2_d.xl  = s1_q.x[W+1:0];
    s2_d.q   = (W+1)'(({{(W+1){1'b0}}, x_hi} * {{(W+1){1'b0}}, t_q}) >> (W+1));

    // The estimate undershoots by at most 2P, so W+2 bits of the difference suffice.
    s3_d     = '0;
    s3_d.vld = s2_q.vld;
    s3_d.tag = s2_q.tag;
    s3_d.r   = s2_q.xl - qp_lo;
  end

  always_comb begin
    c_d = W'(s3_q.r);
    if (s3_q.r >= p2) begin
      c_d = W'(s3_q.r - p2);
    end else if (s3_q.r >= p1) begin
      c_d = W'(s3_q.r - p1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      t_q      <= '0;
      loaded_q <= 1'b0;
    end else if (cfg_we && cfg_ready) begin
      p_q      <= cfg_p;
      t_q      <= cfg_t;
      loaded_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      out_valid <= s3_q.vld;
      if (s3_q.vld) begin
        out_c   <= c_d;
        out_tag <= s3_q.tag;
      end
    end
  end

endmodule
